// File: rtl/antitheft_ctrl_multi.sv
// Vehicle anti-theft controller: multi-door entry delay, timed siren with retrigger lockout,
// passive re-arming after the driver leaves, and latched door-zone / alarm-count reporting.
module antitheft_ctrl_multi #(
  parameter int NUM_DOORS  = 4,
  parameter int TW         = 6,
  parameter int T_DRV      = 8,
  parameter int T_PASS     = 15,
  parameter int T_ALARM    = 10,
  parameter int T_ARM      = 6,
  parameter int MAX_RETRIG = 3
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              ignition,
  input  logic [NUM_DOORS-1:0]              doors,
  input  logic                              reprogram,
  input  logic                              one_hz_enable,
  output logic                              status,
  output logic                              siren,
  output logic [2:0]                        state,
  output logic [$clog2(MAX_RETRIG+1)-1:0]   alarm_count,
  output logic [NUM_DOORS-1:0]              zone_latched
);

  localparam int CW = $clog2(MAX_RETRIG + 1);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    ENTRY      = 3'd1,
    ALARM      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DLY    = 3'd6,
    LOCKOUT    = 3'd7
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   load_val;
  logic            load;
  logic            clr;
  logic            inc;
  logic            blink_q;
  logic [CW-1:0]   count_q;
  logic [NUM_DOORS-1:0] zone_q;
  logic            expired;

  assign expired = (timer_q == '0);

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = '0;
    clr      = 1'b0;
    inc      = 1'b0;
    case (state_q)
      ARMED: begin
        if (|doors) begin
          state_d  = ENTRY;
          load     = 1'b1;
          load_val = (|doors[NUM_DOORS-1:1]) ? TW'(T_PASS) : TW'(T_DRV);
        end else if (ignition) begin
          state_d = DISARMED;
        end
      end
      ENTRY: begin
        if (expired) begin
          state_d  = ALARM;
          load     = 1'b1;
          load_val = TW'(T_ALARM);
          inc      = 1'b1;
        end else if (reprogram) begin
          state_d = ARMED;
          clr     = 1'b1;
        end else if (ignition) begin
          state_d = DISARMED;
        end
      end
      ALARM: begin
        if (reprogram) begin
          state_d = ARMED;
          clr     = 1'b1;
        end else if (ignition) begin
          state_d = DISARMED;
        end else if (expired) begin
          state_d = (count_q == CW'(MAX_RETRIG)) ? LOCKOUT : ARMED;
        end
      end
      DISARMED: begin
        if (!ignition) begin
          state_d = WAIT_OPEN;
        end else if (reprogram) begin
          state_d = ARMED;
          clr     = 1'b1;
        end
      end
      WAIT_OPEN: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (doors[0]) begin
          state_d = WAIT_CLOSE;
        end else if (reprogram) begin
          state_d = ARMED;
          clr     = 1'b1;
        end
      end
      WAIT_CLOSE: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (!doors[0]) begin
          state_d  = ARM_DLY;
          load     = 1'b1;
          load_val = TW'(T_ARM);
        end
      end
      ARM_DLY: begin
        if (ignition) begin
          state_d = DISARMED;
        end else if (|doors) begin
          load     = 1'b1;
          load_val = TW'(T_ARM);
        end else if (expired || reprogram) begin
          state_d = ARMED;
          clr     = reprogram;
        end
      end
      LOCKOUT: begin
        if (reprogram) begin
          state_d = ARMED;
          clr     = 1'b1;
        end else if (ignition) begin
          state_d = DISARMED;
        end
      end
      default: state_d = ARMED;
    endcase
    if (state_d == DISARMED && state_q != DISARMED) clr = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARMED;
      timer_q <= '0;
      blink_q <= 1'b0;
      count_q <= '0;
      zone_q  <= '0;
    end else begin
      state_q <= state_d;

      if (load)                           timer_q <= load_val;
      else if (one_hz_enable && !expired) timer_q <= timer_q - 1'b1;

      // The blink phase restarts dark each time the car re-arms.
      if (state_d == ARMED && state_q != ARMED) blink_q <= 1'b0;
      else if (one_hz_enable)                   blink_q <= ~blink_q;

      if (clr)                                       count_q <= '0;
      else if (inc && count_q != CW'(MAX_RETRIG))    count_q <= count_q + 1'b1;

      if (clr)                                                         zone_q <= '0;
      else if (state_q == ARMED || state_q == ENTRY || state_q == ALARM) zone_q <= zone_q | doors;
    end
  end

  always_comb begin
    status = 1'b0;
    case (state_q)
      ARMED:                  status = blink_q;
      ENTRY, ALARM, LOCKOUT:  status = 1'b1;
      default:                status = 1'b0;
    endcase
  end

  assign siren        = (state_q == ALARM);
  assign state        = state_q;
  assign alarm_count  = count_q;
  assign zone_latched = zone_q;

endmodule

// File: tb/tb_antitheft_ctrl_multi.sv
// Self-checking bench for antitheft_ctrl_multi: directed scenarios plus a randomized run,
// all compared cycle by cycle against a tick-counting reference model.
module tb_antitheft_ctrl_multi;

  localparam int NUM_DOORS  = 4;
  localparam int TW         = 6;
  localparam int T_DRV      = 8;
  localparam int T_PASS     = 15;
  localparam int T_ALARM    = 10;
  localparam int T_ARM      = 6;
  localparam int MAX_RETRIG = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       ignition;
  logic [3:0] doors;
  logic       reprogram;
  logic       one_hz_enable;
  logic       status;
  logic       siren;
  logic [2:0] state;
  logic [1:0] alarm_count;
  logic [3:0] zone_latched;

  int checks   = 0;
  int failures = 0;

  // Reference model: timer kept as "ticks seen since load" against a duration.
  int         m_state;
  int         m_elapsed;
  int         m_dur;
  int         m_count;
  logic [3:0] m_zone;
  logic       m_blink;

  antitheft_ctrl_multi #(
    .NUM_DOORS(NUM_DOORS), .TW(TW), .T_DRV(T_DRV), .T_PASS(T_PASS),
    .T_ALARM(T_ALARM), .T_ARM(T_ARM), .MAX_RETRIG(MAX_RETRIG)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ignition     (ignition),
    .doors        (doors),
    .reprogram    (reprogram),
    .one_hz_enable(one_hz_enable),
    .status       (status),
    .siren        (siren),
    .state        (state),
    .alarm_count  (alarm_count),
    .zone_latched (zone_latched)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_elapsed = 0;
    m_dur     = 0;
    m_count   = 0;
    m_zone    = '0;
    m_blink   = 1'b0;
  endtask

  task automatic model_step();
    bit done = (m_elapsed >= m_dur);
    int nxt  = m_state;
    int ld   = -1;
    bit clr  = 0;
    bit inc  = 0;
    case (m_state)
      0: if (doors != 0) begin nxt = 1; ld = (doors[3:1] != 0) ? T_PASS : T_DRV; end
         else if (ignition) nxt = 3;
      1: if (done) begin nxt = 2; ld = T_ALARM; inc = 1; end
         else if (reprogram) begin nxt = 0; clr = 1; end
         else if (ignition) nxt = 3;
      2: if (reprogram) begin nxt = 0; clr = 1; end
         else if (ignition) nxt = 3;
         else if (done) nxt = (m_count == MAX_RETRIG) ? 7 : 0;
      3: if (!ignition) nxt = 4;
         else if (reprogram) begin nxt = 0; clr = 1; end
      4: if (ignition) nxt = 3;
         else if (doors[0]) nxt = 5;
         else if (reprogram) begin nxt = 0; clr = 1; end
      5: if (ignition) nxt = 3;
         else if (!doors[0]) begin nxt = 6; ld = T_ARM; end
      6: if (ignition) nxt = 3;
         else if (doors != 0) ld = T_ARM;
         else if (done || reprogram) begin nxt = 0; clr = reprogram; end
      default: if (reprogram) begin nxt = 0; clr = 1; end
               else if (ignition) nxt = 3;
    endcase
    if (nxt == 3 && m_state != 3) clr = 1;

    if (ld >= 0) begin m_dur = ld; m_elapsed = 0; end
    else if (one_hz_enable && m_elapsed < m_dur) m_elapsed++;

    if (clr) m_count = 0;
    else if (inc && m_count < MAX_RETRIG) m_count++;

    if (clr) m_zone = '0;
    else if (m_state <= 2) m_zone = m_zone | doors;

    if (nxt == 0 && m_state != 0) m_blink = 1'b0;
    else if (one_hz_enable) m_blink = ~m_blink;

    m_state = nxt;
  endtask

  task automatic compare_all(input string tag);
    logic exp_status;
    exp_status = (m_state == 0) ? m_blink : ((m_state == 1 || m_state == 2 || m_state == 7) ? 1'b1 : 1'b0);
    check({tag, ".state"},  32'(state),        32'(m_state));
    check({tag, ".status"}, 32'(status),       32'(exp_status));
    check({tag, ".siren"},  32'(siren),        32'(m_state == 2));
    check({tag, ".count"},  32'(alarm_count),  32'(m_count));
    check({tag, ".zone"},   32'(zone_latched), 32'(m_zone));
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_step();
    #1;
    compare_all(tag);
  endtask

  initial begin
    int n;
    reset = 1'b1; ignition = 1'b0; doors = '0; reprogram = 1'b0; one_hz_enable = 1'b0;
    model_reset();
    #12;
    check("rst_state",  32'(state), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_siren",  32'(siren), 32'd0);
    check("rst_count",  32'(alarm_count), 32'd0);
    check("rst_zone",   32'(zone_latched), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    one_hz_enable = 1'b1;

    // Driver door: entry delay T_DRV, then alarm.
    doors = 4'b0001;
    step("s1");
    check("s1_entry", 32'(state), 32'd1);
    repeat (8) step("s1");
    check("s1_still_entry", 32'(state), 32'd1);
    step("s1");
    check("s1_alarm", 32'(state), 32'd2);
    check("s1_siren", 32'(siren), 32'd1);
    check("s1_count", 32'(alarm_count), 32'd1);
    check("s1_zone",  32'(zone_latched), 32'b0001);
    doors = '0; reprogram = 1'b1;
    step("s1r");
    reprogram = 1'b0;
    check("s1r_state", 32'(state), 32'd0);
    check("s1r_count", 32'(alarm_count), 32'd0);

    // Passenger door, disarmed by ignition during the entry delay.
    doors = 4'b0100;
    step("s2");
    check("s2_entry", 32'(state), 32'd1);
    doors = '0;
    repeat (4) step("s2");
    ignition = 1'b1;
    step("s2");
    check("s2_disarmed", 32'(state), 32'd3);
    check("s2_count", 32'(alarm_count), 32'd0);
    check("s2_zone",  32'(zone_latched), 32'd0);

    // Passive re-arm with a door reopening during the arming delay.
    ignition = 1'b0;
    step("s4");
    check("s4_wait_open", 32'(state), 32'd4);
    doors = 4'b0001;
    step("s4");
    check("s4_wait_close", 32'(state), 32'd5);
    doors = '0;
    step("s4");
    check("s4_arm_dly", 32'(state), 32'd6);
    repeat (3) step("s4");
    doors = 4'b0100;
    step("s4");
    check("s4_reload", 32'(state), 32'd6);
    doors = '0;
    repeat (6) step("s4");
    check("s4_hold", 32'(state), 32'd6);
    step("s4");
    check("s4_armed", 32'(state), 32'd0);

    // Door held open: three alarm cycles then lockout.
    doors = 4'b0001;
    n = 0;
    while (state !== 3'd7 && n < 200) begin
      step("s3");
      n++;
    end
    check("s3_cycles", 32'(n), 32'd63);
    check("s3_lockout", 32'(state), 32'd7);
    check("s3_status", 32'(status), 32'd1);
    check("s3_siren", 32'(siren), 32'd0);
    check("s3_count", 32'(alarm_count), 32'd3);
    doors = '0; reprogram = 1'b1;
    step("s3r");
    reprogram = 1'b0;
    check("s3r_state", 32'(state), 32'd0);
    check("s3r_zone",  32'(zone_latched), 32'd0);

    // Door beats ignition in ARMED; reprogram beats ignition in ENTRY.
    doors = 4'b0001; ignition = 1'b1;
    step("s5");
    check("s5_entry", 32'(state), 32'd1);
    doors = '0; reprogram = 1'b1;
    step("s5");
    check("s5_armed", 32'(state), 32'd0);
    check("s5_zone",  32'(zone_latched), 32'd0);
    reprogram = 1'b0; ignition = 1'b0;

    // Asynchronous reset in the middle of an alarm.
    doors = 4'b0001;
    repeat (10) step("s6");
    check("s6_alarm", 32'(siren), 32'd1);
    doors = '0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("s6_siren_async", 32'(siren), 32'd0);
    check("s6_state", 32'(state), 32'd0);
    check("s6_count", 32'(alarm_count), 32'd0);
    check("s6_zone",  32'(zone_latched), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic against the model.
    repeat (600) begin
      if ($urandom_range(0, 19) == 0) ignition = ~ignition;
      doors         = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      reprogram     = ($urandom_range(0, 14) == 0);
      one_hz_enable = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
